// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder (MEM-stage slave); optional fault reporting under DMEM_ERR_EN
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        stall_o
);

  localparam int         DEPTH  = 1 << ADDR_W;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_cnt;
  logic               r_we;
  logic [3:0]         r_be;
  logic [ADDR_W-1:0]  r_idx;
  logic [31:0]        r_wdata;
  logic               r_ack;
  logic               r_err;
  logic [31:0]        r_rdata;
  logic [31:0]        r_mem [DEPTH];

  logic w_accept;
  logic w_done;
  logic w_fault;

  // IDLE samples a request; BUSY with an expired counter is the access edge
  assign w_accept = (r_state == S_IDLE) && req_i;
  assign w_done   = (r_state == S_BUSY) && (r_cnt == 4'd0);

`ifdef DMEM_ERR_EN
  logic r_fault;

  // Fault is classified from the payload at acceptance and carried with the access
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_fault <= 1'b0;
    end else if (w_accept) begin
      r_fault <= ((addr_i[1:0] != 2'b00) && (!we_i || (be_i == 4'hF))) ||
                 (addr_i[31:ADDR_W+2] != '0);
    end
  end

  assign w_fault = r_fault;
`else
  logic w_unused_addr;

  // Byte offset and upper address bits are don't-care: the index wraps
  assign w_unused_addr = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};
  assign w_fault       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: RESP always returns to IDLE so a held req_i is not re-accepted in RESP
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (req_i) w_state_nxt = S_BUSY;
      S_BUSY:  if (r_cnt == 4'd0) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Latch the request payload at acceptance and run the latency counter
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_be    <= 4'h0;
      r_idx   <= '0;
      r_wdata <= 32'h0;
    end else if (w_accept) begin
      r_cnt   <= LAT_M1;
      r_we    <= we_i;
      r_be    <= be_i;
      r_idx   <= addr_i[ADDR_W+1:2];
      r_wdata <= wdata_i;
    end else if ((r_state == S_BUSY) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Byte-masked store at the access edge; reset forces IDLE so an aborted access never writes
  always_ff @(posedge clk_i) begin
    if (w_done && r_we && !w_fault) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[b]) begin
          r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
    end
  end

  // Response: one-cycle ack, error alongside it, read data held until the next load or fault
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      r_ack <= w_done;
      r_err <= w_done && w_fault;
      if (w_done) begin
        if (w_fault) begin
          r_rdata <= 32'hDEAD_BEEF;
        end else if (!r_we) begin
          r_rdata <= r_mem[r_idx];
        end
      end
    end
  end

  assign ack_o   = r_ack;
  assign err_o   = r_err;
  assign rdata_o = r_rdata;
  assign stall_o = req_i & ~r_ack;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder (LATENCY=3 and LATENCY=1 instances)
module tb_dmem_responder;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic        clk;
  logic        rst;
  logic        req   [2];
  logic        we    [2];
  logic [3:0]  be    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        ack   [2];
  logic [31:0] rdata [2];
  logic        err   [2];
  logic        stall [2];

  int lat_of [2] = '{3, 1};

  int errors = 0;
  int checks = 0;

  bit [31:0] mmem [int];
  bit [31:0] mrd  [2];

  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(3)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]), .be_i(be[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .ack_o(ack[0]), .rdata_o(rdata[0]),
    .err_o(err[0]), .stall_o(stall[0])
  );

  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]), .be_i(be[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .ack_o(ack[1]), .rdata_o(rdata[1]),
    .err_o(err[1]), .stall_o(stall[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: word array per instance, fault rules from the address map
  function automatic void model(input int d, input bit w, input bit [3:0] b, input bit [31:0] a,
                                input bit [31:0] wd, output bit [31:0] erd, output bit eerr);
    int        idx;
    int        key;
    bit        fault;
    bit [31:0] word;
    idx   = int'((a >> 2) % DEPTH);
    key   = d * DEPTH + idx;
    fault = 1'b0;
`ifdef DMEM_ERR_EN
    fault = ((a % 4) != 0 && (!w || b == 4'hF)) || ((a >> (ADDR_W + 2)) != 0);
`endif
    eerr = fault;
    if (fault) begin
      mrd[d] = 32'hDEAD_BEEF;
    end else if (w) begin
      word = mmem.exists(key) ? mmem[key] : 32'h0;
      for (int i = 0; i < 4; i++)
        if (b[i]) word[8*i +: 8] = wd[8*i +: 8];
      mmem[key] = word;
    end else begin
      mrd[d] = mmem.exists(key) ? mmem[key] : 32'h0;
    end
    erd = mrd[d];
  endfunction

  // Drive one request, scramble the payload after acceptance, wait for ack
  task automatic access(input int d, input bit w, input bit [3:0] b, input bit [31:0] a,
                        input bit [31:0] wd, output bit [31:0] rd, output bit er,
                        output int lat, output int stalls);
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
    #1 stalls = int'(stall[d]);
    @(posedge clk);
    #1;
    we[d] = 1'($urandom); be[d] = 4'($urandom); addr[d] = $urandom; wdata[d] = $urandom;
    lat = 0;
    while (!ack[d] && lat < 40) begin
      stalls += int'(stall[d]);
      @(posedge clk);
      #1 lat++;
    end
    if (!ack[d]) lat = -1;
    rd = rdata[d];
    er = err[d];
    @(negedge clk);
    req[d] = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; be[d] = 4'h0; addr[d] = 32'h0; wdata[d] = 32'h0;
      mrd[d] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (ack[d] !== 1'b0) begin errors++; $display("FAIL reset_ack[%0d]: got %b expected 0", d, ack[d]); end
      checks++; if (err[d] !== 1'b0) begin errors++; $display("FAIL reset_err[%0d]: got %b expected 0", d, err[d]); end
      checks++; if (rdata[d] !== 32'h0) begin errors++; $display("FAIL reset_rdata[%0d]: got %h expected 0", d, rdata[d]); end
      req[d] = 1'b1;
      #1;
      checks++; if (stall[d] !== 1'b1) begin errors++; $display("FAIL reset_stall[%0d]: got %b expected 1", d, stall[d]); end
      req[d] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_store_load;
    bit [31:0] rd, erd;
    bit        er, eer;
    int        lat, st;
    access(0, 1'b1, 4'hF, 32'h10, 32'hCAFE_F00D, rd, er, lat, st);
    model(0, 1'b1, 4'hF, 32'h10, 32'hCAFE_F00D, erd, eer);
    checks++; if (lat !== 3) begin errors++; $display("FAIL store_latency: got %0d expected 3", lat); end
    checks++; if (st !== 4) begin errors++; $display("FAIL store_stall_cycles: got %0d expected 4", st); end
    checks++; if (rd !== erd) begin errors++; $display("FAIL store_rdata_held: got %h expected %h", rd, erd); end
    access(0, 1'b0, 4'h0, 32'h10, 32'h0, rd, er, lat, st);
    model(0, 1'b0, 4'h0, 32'h10, 32'h0, erd, eer);
    checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL load_rdata: got %h expected cafef00d", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL load_err: got %b expected 0", er); end
    @(posedge clk);
    #1;
    checks++; if (rdata[0] !== 32'hCAFE_F00D) begin errors++; $display("FAIL rdata_hold_after_ack: got %h expected cafef00d", rdata[0]); end
  endtask

  task automatic test_byte_enables;
    bit [31:0] rd, erd;
    bit        er, eer;
    int        lat, st;
    access(0, 1'b1, 4'hF, 32'h20, 32'h1122_3344, rd, er, lat, st);
    model(0, 1'b1, 4'hF, 32'h20, 32'h1122_3344, erd, eer);
    access(0, 1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD, rd, er, lat, st);
    model(0, 1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD, erd, eer);
    access(0, 1'b0, 4'h0, 32'h20, 32'h0, rd, er, lat, st);
    model(0, 1'b0, 4'h0, 32'h20, 32'h0, erd, eer);
    checks++; if (rd !== 32'h11BB_33DD) begin errors++; $display("FAIL be_0101: got %h expected 11bb33dd", rd); end
    access(0, 1'b1, 4'h0, 32'h20, 32'hFFFF_FFFF, rd, er, lat, st);
    model(0, 1'b1, 4'h0, 32'h20, 32'hFFFF_FFFF, erd, eer);
    checks++; if (lat !== 3) begin errors++; $display("FAIL be_0000_latency: got %0d expected 3", lat); end
    access(0, 1'b0, 4'h0, 32'h20, 32'h0, rd, er, lat, st);
    model(0, 1'b0, 4'h0, 32'h20, 32'h0, erd, eer);
    checks++; if (rd !== 32'h11BB_33DD) begin errors++; $display("FAIL be_0000_nowrite: got %h expected 11bb33dd", rd); end
  endtask

  task automatic test_reset_mid_busy;
    bit [31:0] rd, erd;
    bit        er, eer;
    int        lat, st;
    access(0, 1'b1, 4'hF, 32'h40, 32'hA5A5_0001, rd, er, lat, st);
    model(0, 1'b1, 4'hF, 32'h40, 32'hA5A5_0001, erd, eer);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h40; wdata[0] = 32'h1234_5678;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0; req[0] = 1'b0;
    #1;
    checks++; if (ack[0] !== 1'b0) begin errors++; $display("FAIL midreset_ack: got %b expected 0", ack[0]); end
    checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL midreset_err: got %b expected 0", err[0]); end
    checks++; if (rdata[0] !== 32'h0) begin errors++; $display("FAIL midreset_rdata: got %h expected 0", rdata[0]); end
    @(negedge clk);
    rst = 1'b1;
    mrd[0] = 32'h0;
    mrd[1] = 32'h0;
    access(0, 1'b0, 4'h0, 32'h40, 32'h0, rd, er, lat, st);
    model(0, 1'b0, 4'h0, 32'h40, 32'h0, erd, eer);
    checks++; if (lat !== 3) begin errors++; $display("FAIL midreset_load_latency: got %0d expected 3", lat); end
    checks++; if (rd !== 32'hA5A5_0001) begin errors++; $display("FAIL midreset_no_write: got %h expected a5a50001", rd); end
  endtask

  task automatic test_held_request;
    int n;
    int extra;
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; be[0] = 4'h0; addr[0] = 32'h10; wdata[0] = 32'h0;
    @(posedge clk);
    #1 n = 0;
    while (!ack[0] && n < 40) begin @(posedge clk); #1 n++; end
    checks++; if (n !== 3) begin errors++; $display("FAIL held_first_latency: got %0d expected 3", n); end
    @(posedge clk);
    #1;
    checks++; if (ack[0] !== 1'b0) begin errors++; $display("FAIL held_no_ack_resp_plus1: got %b expected 0", ack[0]); end
    @(posedge clk);
    @(negedge clk);
    req[0] = 1'b0;
    #1 n = 0;
    while (!ack[0] && n < 40) begin @(posedge clk); #1 n++; end
    checks++; if (n !== 3) begin errors++; $display("FAIL held_second_latency: got %0d expected 3", n); end
    checks++; if (rdata[0] !== 32'hCAFE_F00D) begin errors++; $display("FAIL held_second_rdata: got %h expected cafef00d", rdata[0]); end
    extra = 0;
    repeat (10) begin @(posedge clk); #1 extra += int'(ack[0]); end
    checks++; if (extra !== 0) begin errors++; $display("FAIL held_extra_acks: got %0d expected 0", extra); end
    mrd[0] = 32'hCAFE_F00D;
  endtask

  task automatic test_latency1_sweep;
    bit [31:0] rd, erd, wd;
    bit        er, eer;
    int        lat, st;
    for (int i = 0; i < 8; i++) begin
      wd = $urandom;
      access(1, 1'b1, 4'hF, 32'(4 * i), wd, rd, er, lat, st);
      model(1, 1'b1, 4'hF, 32'(4 * i), wd, erd, eer);
      checks++; if (lat !== 1) begin errors++; $display("FAIL lat1_store_latency[%0d]: got %0d expected 1", i, lat); end
      access(1, 1'b0, 4'h0, 32'(4 * i), 32'h0, rd, er, lat, st);
      model(1, 1'b0, 4'h0, 32'(4 * i), 32'h0, erd, eer);
      checks++; if (lat !== 1) begin errors++; $display("FAIL lat1_load_latency[%0d]: got %0d expected 1", i, lat); end
      checks++; if (rd !== wd) begin errors++; $display("FAIL lat1_load_data[%0d]: got %h expected %h", i, rd, wd); end
    end
  endtask

  task automatic test_random;
    bit [31:0] rd, erd, a, wd;
    bit [3:0]  b;
    bit        w, er, eer;
    int        lat, st, d;
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 2; k++) begin
        wd = $urandom;
        access(k, 1'b1, 4'hF, 32'(4 * i), wd, rd, er, lat, st);
        model(k, 1'b1, 4'hF, 32'(4 * i), wd, erd, eer);
      end
    end
    for (int i = 0; i < 60; i++) begin
      d  = i % 2;
      w  = 1'($urandom);
      b  = 4'($urandom);
      wd = $urandom;
      a  = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 3) == 0) a |= 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a |= 32'h1 << $urandom_range(ADDR_W + 2, 31);
      access(d, w, b, a, wd, rd, er, lat, st);
      model(d, w, b, a, wd, erd, eer);
      checks++; if (lat !== lat_of[d]) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, lat_of[d]); end
      checks++; if (rd !== erd) begin errors++; $display("FAIL rand_rdata[%0d] d=%0d we=%b be=%h a=%h: got %h expected %h", i, d, w, b, a, rd, erd); end
      checks++; if (er !== eer) begin errors++; $display("FAIL rand_err[%0d] a=%h: got %b expected %b", i, a, er, eer); end
    end
  endtask

  task automatic test_err;
    bit [31:0] rd, erd;
    bit        er, eer;
    int        lat, st;
    access(0, 1'b1, 4'hF, 32'h0, 32'h0BAD_F00D, rd, er, lat, st);
    model(0, 1'b1, 4'hF, 32'h0, 32'h0BAD_F00D, erd, eer);
    access(0, 1'b0, 4'h0, 32'h2, 32'h0, rd, er, lat, st);
    model(0, 1'b0, 4'h0, 32'h2, 32'h0, erd, eer);
`ifdef DMEM_ERR_EN
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_misaligned_flag: got %b expected 1", er); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL err_misaligned_rdata: got %h expected deadbeef", rd); end
`else
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL noerr_misaligned_flag: got %b expected 0", er); end
    checks++; if (rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL noerr_misaligned_rdata: got %h expected 0badf00d", rd); end
`endif
    access(0, 1'b1, 4'hF, 32'h0001_0000, 32'h7777_7777, rd, er, lat, st);
    model(0, 1'b1, 4'hF, 32'h0001_0000, 32'h7777_7777, erd, eer);
    checks++; if (er !== eer) begin errors++; $display("FAIL err_range_flag: got %b expected %b", er, eer); end
    checks++; if (rd !== erd) begin errors++; $display("FAIL err_range_rdata: got %h expected %h", rd, erd); end
    access(0, 1'b0, 4'h0, 32'h0, 32'h0, rd, er, lat, st);
    model(0, 1'b0, 4'h0, 32'h0, 32'h0, erd, eer);
    checks++; if (rd !== erd) begin errors++; $display("FAIL err_range_array: got %h expected %h", rd, erd); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_enables();
    test_reset_mid_busy();
    test_held_request();
    test_latency1_sweep();
    test_random();
    test_err();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
